// File: rtl/link_queue_controller.sv
// Multi-queue linked-list page manager: one free list plus QUEUE_NUM page queues sharing a next-pointer table.
// Optional occupancy outputs (queue_count, free_count) are enabled by defining LINK_QUEUE_OCCUPANCY_EN.
module link_queue_controller #(
  parameter int unsigned ADDR_WIDTH   = 8,
  parameter int unsigned PAGE_NUM_LOG = 4,
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned QUEUE_NUM    = 4,
  parameter int unsigned QID_WIDTH    = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [QID_WIDTH-1:0]    cmd_queue,
  output logic                    cmd_err,
  output logic                    wr_data_req,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  output logic                    ram_we,
  output logic                    ram_re,
  output logic [ADDR_WIDTH-1:0]   ram_addr,
  output logic [DATA_WIDTH-1:0]   ram_wdata,
  input  logic [DATA_WIDTH-1:0]   ram_rdata,
  output logic                    rd_valid,
  output logic [DATA_WIDTH-1:0]   rd_data,
  output logic [QUEUE_NUM-1:0]    queue_empty,
  output logic                    free_empty
`ifdef LINK_QUEUE_OCCUPANCY_EN
  ,
  output logic [QUEUE_NUM*(PAGE_NUM_LOG+1)-1:0] queue_count,
  output logic [PAGE_NUM_LOG:0]                 free_count
`endif
);

  localparam int unsigned OFS_W = ADDR_WIDTH - PAGE_NUM_LOG;
  localparam int unsigned PAGES = 2 ** PAGE_NUM_LOG;
  localparam int unsigned CNT_W = PAGE_NUM_LOG + 1;

  typedef logic [PAGE_NUM_LOG-1:0] page_t;
  typedef logic [CNT_W-1:0]        cnt_t;
  typedef logic [OFS_W-1:0]        ofs_t;

  typedef enum logic [2:0] {
    S_INIT,
    S_IDLE,
    S_LOOKUP,
    S_STREAM,
    S_LINK
  } state_e;

  state_e                state_q, state_d;
  page_t                 init_cnt_q, init_cnt_d;
  page_t                 page_q, page_d;
  logic [QID_WIDTH-1:0]  qid_q, qid_d;
  logic                  wr_q, wr_d;
  ofs_t                  cnt_q, cnt_d;
  page_t                 nxt_q, nxt_d;
  page_t                 free_head_q, free_head_d;
  page_t                 free_tail_q, free_tail_d;
  cnt_t                  free_cnt_q, free_cnt_d;
  page_t                 head_q [QUEUE_NUM];
  page_t                 head_d [QUEUE_NUM];
  page_t                 tail_q [QUEUE_NUM];
  page_t                 tail_d [QUEUE_NUM];
  cnt_t                  qcnt_q [QUEUE_NUM];
  cnt_t                  qcnt_d [QUEUE_NUM];

  logic                  cmd_ready_q, cmd_ready_d;
  logic                  cmd_err_q, cmd_err_d;
  logic                  wr_data_req_q, wr_data_req_d;
  logic                  ram_we_q, ram_we_d;
  logic                  ram_re_q, ram_re_d;
  logic [ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
  logic                  rd_valid_q, rd_valid_d;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic [QUEUE_NUM-1:0]  queue_empty_q, queue_empty_d;
  logic                  free_empty_q, free_empty_d;

  // Single-write-port next-pointer table
  page_t                 next_q [PAGES];
  logic                  nt_we;
  page_t                 nt_waddr;
  page_t                 nt_wdata;

  logic                  reject;
  logic                  streaming_d;

  // Next-state, list maintenance and registered-output decode
  always_comb begin
    state_d       = state_q;
    init_cnt_d    = init_cnt_q;
    page_d        = page_q;
    qid_d         = qid_q;
    wr_d          = wr_q;
    cnt_d         = cnt_q;
    nxt_d         = nxt_q;
    free_head_d   = free_head_q;
    free_tail_d   = free_tail_q;
    free_cnt_d    = free_cnt_q;
    head_d        = head_q;
    tail_d        = tail_q;
    qcnt_d        = qcnt_q;
    nt_we         = 1'b0;
    nt_waddr      = '0;
    nt_wdata      = '0;
    cmd_err_d     = 1'b0;
    reject        = 1'b0;

    unique case (state_q)
      S_INIT: begin
        nt_we       = 1'b1;
        nt_waddr    = init_cnt_q;
        nt_wdata    = page_t'(init_cnt_q + page_t'(1));
        free_head_d = '0;
        free_tail_d = page_t'(PAGES - 1);
        free_cnt_d  = cnt_t'(PAGES);
        init_cnt_d  = page_t'(init_cnt_q + page_t'(1));
        if (init_cnt_q == page_t'(PAGES - 1)) begin
          state_d = S_IDLE;
        end
      end
      S_IDLE: begin
        if (cmd_valid) begin
          reject = cmd_write ? (free_cnt_q == '0) : (qcnt_q[cmd_queue] == '0);
          if (reject) begin
            cmd_err_d = 1'b1;
          end else begin
            wr_d    = cmd_write;
            qid_d   = cmd_queue;
            page_d  = cmd_write ? free_head_q : head_q[cmd_queue];
            state_d = S_LOOKUP;
          end
        end
      end
      S_LOOKUP: begin
        nxt_d   = next_q[page_q];
        cnt_d   = '0;
        state_d = S_STREAM;
      end
      S_STREAM: begin
        if (cnt_q == {OFS_W{1'b1}}) begin
          state_d = S_LINK;
        end else begin
          cnt_d = ofs_t'(cnt_q + ofs_t'(1));
        end
      end
      S_LINK: begin
        state_d = S_IDLE;
        if (wr_q) begin
          // Pop the free head, push the page onto the queue tail
          free_head_d   = nxt_q;
          free_cnt_d    = cnt_t'(free_cnt_q - cnt_t'(1));
          qcnt_d[qid_q] = cnt_t'(qcnt_q[qid_q] + cnt_t'(1));
          tail_d[qid_q] = page_q;
          if (qcnt_q[qid_q] == '0) begin
            head_d[qid_q] = page_q;
          end else begin
            nt_we    = 1'b1;
            nt_waddr = tail_q[qid_q];
            nt_wdata = page_q;
          end
        end else begin
          // Pop the queue head, return the page to the free tail
          head_d[qid_q] = nxt_q;
          qcnt_d[qid_q] = cnt_t'(qcnt_q[qid_q] - cnt_t'(1));
          free_cnt_d    = cnt_t'(free_cnt_q + cnt_t'(1));
          free_tail_d   = page_q;
          if (free_cnt_q == '0) begin
            free_head_d = page_q;
          end else begin
            nt_we    = 1'b1;
            nt_waddr = free_tail_q;
            nt_wdata = page_q;
          end
        end
      end
      default: begin
        state_d = S_INIT;
      end
    endcase

    streaming_d   = (state_d == S_STREAM);
    cmd_ready_d   = (state_d == S_IDLE);
    wr_data_req_d = streaming_d && wr_q;
    ram_we_d      = streaming_d && wr_q;
    ram_re_d      = streaming_d && !wr_q;
    ram_addr_d    = streaming_d ? {page_q, cnt_d} : '0;
    rd_valid_d    = ram_re_q;
    rd_data_d     = ram_re_q ? ram_rdata : rd_data_q;
    for (int unsigned i = 0; i < QUEUE_NUM; i++) begin
      queue_empty_d[i] = (qcnt_d[i] == '0);
    end
    free_empty_d  = (free_cnt_d == '0);
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_INIT;
      init_cnt_q    <= '0;
      page_q        <= '0;
      qid_q         <= '0;
      wr_q          <= 1'b0;
      cnt_q         <= '0;
      nxt_q         <= '0;
      free_head_q   <= '0;
      free_tail_q   <= page_t'(PAGES - 1);
      free_cnt_q    <= cnt_t'(PAGES);
      for (int unsigned i = 0; i < QUEUE_NUM; i++) begin
        head_q[i] <= '0;
        tail_q[i] <= '0;
        qcnt_q[i] <= '0;
      end
      cmd_ready_q   <= 1'b0;
      cmd_err_q     <= 1'b0;
      wr_data_req_q <= 1'b0;
      ram_we_q      <= 1'b0;
      ram_re_q      <= 1'b0;
      ram_addr_q    <= '0;
      rd_valid_q    <= 1'b0;
      rd_data_q     <= '0;
      queue_empty_q <= '1;
      free_empty_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      init_cnt_q    <= init_cnt_d;
      page_q        <= page_d;
      qid_q         <= qid_d;
      wr_q          <= wr_d;
      cnt_q         <= cnt_d;
      nxt_q         <= nxt_d;
      free_head_q   <= free_head_d;
      free_tail_q   <= free_tail_d;
      free_cnt_q    <= free_cnt_d;
      head_q        <= head_d;
      tail_q        <= tail_d;
      qcnt_q        <= qcnt_d;
      cmd_ready_q   <= cmd_ready_d;
      cmd_err_q     <= cmd_err_d;
      wr_data_req_q <= wr_data_req_d;
      ram_we_q      <= ram_we_d;
      ram_re_q      <= ram_re_d;
      ram_addr_q    <= ram_addr_d;
      rd_valid_q    <= rd_valid_d;
      rd_data_q     <= rd_data_d;
      queue_empty_q <= queue_empty_d;
      free_empty_q  <= free_empty_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < PAGES; i++) begin
        next_q[i] <= '0;
      end
    end else if (nt_we) begin
      next_q[nt_waddr] <= nt_wdata;
    end
  end

  assign cmd_ready   = cmd_ready_q;
  assign cmd_err     = cmd_err_q;
  assign wr_data_req = wr_data_req_q;
  assign ram_we      = ram_we_q;
  assign ram_re      = ram_re_q;
  assign ram_addr    = ram_addr_q;
  assign ram_wdata   = wr_data;
  assign rd_valid    = rd_valid_q;
  assign rd_data     = rd_data_q;
  assign queue_empty = queue_empty_q;
  assign free_empty  = free_empty_q;

`ifdef LINK_QUEUE_OCCUPANCY_EN
  always_comb begin
    queue_count = '0;
    for (int unsigned i = 0; i < QUEUE_NUM; i++) begin
      queue_count[i*CNT_W +: CNT_W] = qcnt_q[i];
    end
  end

  assign free_count = free_cnt_q;
`endif

endmodule

// File: tb/tb_link_queue_controller.sv
// Directed bench for link_queue_controller: allocation order, stream timing, rejects, full list, mid-stream reset.
module tb_link_queue_controller;

  logic       clk;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_write;
  logic [1:0] cmd_queue;
  logic       cmd_err;
  logic       wr_data_req;
  logic [7:0] wr_data;
  logic       ram_we;
  logic       ram_re;
  logic [7:0] ram_addr;
  logic [7:0] ram_wdata;
  logic [7:0] ram_rdata;
  logic       rd_valid;
  logic [7:0] rd_data;
  logic [3:0] queue_empty;
  logic       free_empty;
`ifdef LINK_QUEUE_OCCUPANCY_EN
  logic [19:0] queue_count;
  logic [4:0]  free_count;
`endif

  int checks = 0;
  int errors = 0;

  logic [7:0] wr_base;
  logic [7:0] mem [256];

  link_queue_controller dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_write   (cmd_write),
    .cmd_queue   (cmd_queue),
    .cmd_err     (cmd_err),
    .wr_data_req (wr_data_req),
    .wr_data     (wr_data),
    .ram_we      (ram_we),
    .ram_re      (ram_re),
    .ram_addr    (ram_addr),
    .ram_wdata   (ram_wdata),
    .ram_rdata   (ram_rdata),
    .rd_valid    (rd_valid),
    .rd_data     (rd_data),
    .queue_empty (queue_empty),
    .free_empty  (free_empty)
`ifdef LINK_QUEUE_OCCUPANCY_EN
    ,
    .queue_count (queue_count),
    .free_count  (free_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Page RAM model; write data is the page base plus the word offset
  assign wr_data   = 8'(wr_base + 8'(ram_addr[3:0]));
  assign ram_rdata = mem[ram_addr];
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic wr, input logic [1:0] q);
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_queue = q;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic do_write(input logic [1:0] q, input logic [7:0] base, input logic [3:0] pg);
    wr_base = base;
    issue(1'b1, q);
    check("wr_lookup_ready", 32'(cmd_ready), 32'd0);
    check("wr_lookup_we", 32'(ram_we), 32'd0);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      check("wr_stream_we", 32'(ram_we), 32'd1);
      check("wr_stream_req", 32'(wr_data_req), 32'd1);
      check("wr_stream_addr", 32'(ram_addr), 32'({pg, 4'(i)}));
    end
    @(negedge clk);
    check("wr_link_we", 32'(ram_we), 32'd0);
    check("wr_link_ready", 32'(cmd_ready), 32'd0);
    @(negedge clk);
    check("wr_done_ready", 32'(cmd_ready), 32'd1);
  endtask

  task automatic do_read(input logic [1:0] q, input logic [3:0] pg, input logic [7:0] base);
    issue(1'b0, q);
    check("rd_lookup_re", 32'(ram_re), 32'd0);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      check("rd_stream_re", 32'(ram_re), 32'd1);
      check("rd_stream_addr", 32'(ram_addr), 32'({pg, 4'(i)}));
      if (i == 0) begin
        check("rd_valid_first", 32'(rd_valid), 32'd0);
      end else begin
        check("rd_valid", 32'(rd_valid), 32'd1);
        check("rd_data", 32'(rd_data), 32'(8'(base + 8'(i - 1))));
      end
    end
    @(negedge clk);
    check("rd_link_re", 32'(ram_re), 32'd0);
    check("rd_link_valid", 32'(rd_valid), 32'd1);
    check("rd_link_data", 32'(rd_data), 32'(8'(base + 8'd15)));
    @(negedge clk);
    check("rd_done_valid", 32'(rd_valid), 32'd0);
    check("rd_done_ready", 32'(cmd_ready), 32'd1);
  endtask

  task automatic do_reject(input logic wr, input logic [1:0] q);
    issue(wr, q);
    check("rej_err", 32'(cmd_err), 32'd1);
    check("rej_ready", 32'(cmd_ready), 32'd1);
    check("rej_re", 32'(ram_re), 32'd0);
    check("rej_we", 32'(ram_we), 32'd0);
    @(negedge clk);
    check("rej_err_single", 32'(cmd_err), 32'd0);
    check("rej_ready_after", 32'(cmd_ready), 32'd1);
    check("rej_re_after", 32'(ram_re), 32'd0);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_ready"}, 32'(cmd_ready), 32'd0);
    check({tag, "_err"}, 32'(cmd_err), 32'd0);
    check({tag, "_req"}, 32'(wr_data_req), 32'd0);
    check({tag, "_we"}, 32'(ram_we), 32'd0);
    check({tag, "_re"}, 32'(ram_re), 32'd0);
    check({tag, "_rdv"}, 32'(rd_valid), 32'd0);
    check({tag, "_addr"}, 32'(ram_addr), 32'd0);
    check({tag, "_rdata"}, 32'(rd_data), 32'd0);
    check({tag, "_qe"}, 32'(queue_empty), 32'hF);
    check({tag, "_fe"}, 32'(free_empty), 32'd0);
`ifdef LINK_QUEUE_OCCUPANCY_EN
    check({tag, "_qcnt"}, 32'(queue_count), 32'd0);
    check({tag, "_fcnt"}, 32'(free_count), 32'd16);
`endif
  endtask

  task automatic release_and_init(input string tag);
    rst_n = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      check({tag, "_init_ready"}, 32'(cmd_ready), (k == 16) ? 32'd1 : 32'd0);
    end
    check({tag, "_init_qe"}, 32'(queue_empty), 32'hF);
    check({tag, "_init_fe"}, 32'(free_empty), 32'd0);
  endtask

  initial begin
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_queue = 2'd0;
    wr_base   = 8'h00;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;

    repeat (3) @(negedge clk);
    check_reset_values("rst");
    release_and_init("por");

    // Two pages into q2, allocated in free-list order
    do_write(2'd2, 8'h00, 4'd0);
    check("qe_after_w1", 32'(queue_empty), 32'hB);
    do_write(2'd2, 8'h80, 4'd1);
    check("qe_after_w2", 32'(queue_empty), 32'hB);
`ifdef LINK_QUEUE_OCCUPANCY_EN
    check("qcnt_q2_2", 32'(queue_count[14:10]), 32'd2);
    check("fcnt_14", 32'(free_count), 32'd14);
`endif

    // Drain q2 in FIFO order
    do_read(2'd2, 4'd0, 8'h00);
    check("qe_after_r1", 32'(queue_empty), 32'hB);
    do_read(2'd2, 4'd1, 8'h80);
    check("qe_after_r2", 32'(queue_empty), 32'hF);

    // Next allocation is page 2; freed pages sit behind page 15
    do_write(2'd3, 8'h40, 4'd2);
    check("qe_after_w3", 32'(queue_empty), 32'h7);

    do_reject(1'b0, 2'd1);

    do_read(2'd3, 4'd2, 8'h40);
    check("qe_after_r3", 32'(queue_empty), 32'hF);
    check("fe_before_fill", 32'(free_empty), 32'd0);

    // Fill: free order is now 3..15, 0, 1, 2
    for (int k = 0; k < 16; k++) begin
      do_write(2'd0, 8'(8'h07 + 8'(k * 16)), 4'((k + 3) % 16));
      if (k == 14) check("fe_before_last", 32'(free_empty), 32'd0);
    end
    check("fe_full", 32'(free_empty), 32'd1);
    check("qe_full", 32'(queue_empty), 32'hE);
`ifdef LINK_QUEUE_OCCUPANCY_EN
    check("fcnt_0", 32'(free_count), 32'd0);
    check("qcnt_q0_16", 32'(queue_count[4:0]), 32'd16);
`endif

    do_reject(1'b1, 2'd0);
    check("fe_after_rej", 32'(free_empty), 32'd1);

    do_read(2'd0, 4'd3, 8'h07);
    check("fe_after_free", 32'(free_empty), 32'd0);
    check("qe_after_free", 32'(queue_empty), 32'hE);
`ifdef LINK_QUEUE_OCCUPANCY_EN
    check("fcnt_1", 32'(free_count), 32'd1);
`endif

    // Reset in the middle of a write stream
    wr_base = 8'h33;
    issue(1'b1, 2'd1);
    repeat (3) @(negedge clk);
    check("mid_we_before", 32'(ram_we), 32'd1);
    rst_n = 1'b0;
    #1;
    check_reset_values("mid");
    @(negedge clk);
    check_reset_values("mid_hold");
    release_and_init("mid");

    // Lists were rebuilt from scratch
    do_write(2'd1, 8'h60, 4'd0);
    check("qe_post_rst_w", 32'(queue_empty), 32'hD);
    do_read(2'd1, 4'd0, 8'h60);
    check("qe_post_rst_r", 32'(queue_empty), 32'hF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/link_queue_controller.md
# link_queue_controller

Multi-queue linked-list page manager: the parametrised successor to the single-list link controller. It owns a free-page list and QUEUE_NUM independent page queues, all held in one internal next-pointer table. Each command moves one whole page between the external data RAM and a selected queue. It sits between the dataflow controller and the shared page RAM, and initialises its own free list after reset.

## Interface
- ADDR_WIDTH, 8: RAM word address width.
- PAGE_NUM_LOG, 4: log2 of the page count. Page number is ram_addr[ADDR_WIDTH-1 -: PAGE_NUM_LOG].
- DATA_WIDTH, 8: word width.
- QUEUE_NUM, 4: number of queues.
- QID_WIDTH, 2: queue-id width, equal to clog2(QUEUE_NUM).
- Derived: OFS_W = ADDR_WIDTH-PAGE_NUM_LOG; PAGE_WORDS = 2^OFS_W; PAGES = 2^PAGE_NUM_LOG.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high only in IDLE.
- cmd_write  in  1  1 = write a page into the queue; 0 = read a page out of the queue.
- cmd_queue  in  QID_WIDTH  target queue.
- cmd_err  out  1  one-cycle pulse when a command is rejected.
- wr_data_req  out  1  word request during write STREAM.
- wr_data  in  DATA_WIDTH  must be valid in the same cycle as wr_data_req.
- ram_we  out  1  RAM write strobe.
- ram_re  out  1  RAM read strobe.
- ram_addr  out  ADDR_WIDTH  {page, offset}.
- ram_wdata  out  DATA_WIDTH  equals wr_data, combinational.
- ram_rdata  in  DATA_WIDTH  returned 1 cycle after ram_re.
- rd_valid  out  1  ram_re delayed 1 cycle.
- rd_data  out  DATA_WIDTH  registered ram_rdata.
- queue_empty  out  QUEUE_NUM  per-queue empty flag.
- free_empty  out  1  no free pages.

## Operation
- States: INIT, IDLE, LOOKUP, STREAM, LINK.
- INIT:
  - Walk i = 0..PAGES-1 and write next[i] = i+1.
  - free_head = 0, free_tail = PAGES-1, free count = PAGES.
  - Go to IDLE after PAGES cycles.
- IDLE: a command is accepted on cmd_valid && cmd_ready.
- Reject rule: a write when free_empty, or a read when queue_empty[q], is rejected.
  - cmd_err pulses on the next cycle.
  - State stays IDLE; no RAM or pointer activity.
- Write of queue q:
  - Latch p = free_head.
  - LOOKUP: read next[p].
  - STREAM: PAGE_WORDS cycles with wr_data_req = ram_we = 1 and ram_addr = {p, cnt}, where cnt = 0..PAGE_WORDS-1.
  - LINK: free_head <= next[p].
  - LINK: if q is empty, head[q] = tail[q] = p; otherwise next[tail[q]] <= p and tail[q] <= p.
- Read of queue q:
  - Latch p = head[q].
  - LOOKUP: read next[p].
  - STREAM: ram_re = 1 with ram_addr = {p, cnt}.
  - LINK: head[q] <= next[p].
  - LINK: p is appended to the free tail (next[free_tail] <= p, or free_head <= p if the free list is empty), and free_tail <= p.
- The next-pointer table takes at most one write per cycle.
- Page counts are PAGE_NUM_LOG+1 bits wide. empty = (count == 0).
- The STREAM counter is OFS_W bits wide and exits on all-ones.
- Only one command is in flight at a time, so concurrent list updates cannot occur.
- Reset at any point, including mid-STREAM, aborts the operation, clears all lists, and re-enters INIT.

## Timing
- Reset values:
  - cmd_ready, cmd_err, wr_data_req, ram_we, ram_re, rd_valid = 0.
  - ram_addr, rd_data = 0.
  - queue_empty = all ones; free_empty = 0.
- cmd_ready is low for PAGES cycles after reset release.
- Command accepted in cycle T:
  - LOOKUP at T+1.
  - STREAM from T+2 to T+1+PAGE_WORDS.
  - LINK at T+2+PAGE_WORDS.
  - cmd_ready high again at T+3+PAGE_WORDS.
- Read data: rd_valid is high from T+3 to T+2+PAGE_WORDS.
- queue_empty and free_empty update in the cycle after LINK.
- After a rejection, cmd_ready stays high.

## Configuration
- LINK_QUEUE_OCCUPANCY_EN defined:
  - Adds the output queue_count, QUEUE_NUM*(PAGE_NUM_LOG+1) bits, with queue q at slice q.
  - Adds the output free_count, PAGE_NUM_LOG+1 bits.
  - Both reset to 0 and PAGES respectively, and update with the flags.
- Undefined: neither port exists. The internal counts are still used for the empty flags.

## Test plan
- Reset release -> cmd_ready low 16 cycles then high; queue_empty = 4'b1111; free_empty = 0.
- Write q2, data 0x00..0x0F -> ram_addr 0x00..0x0F with ram_we; queue_empty[2] = 0. Second write to q2 -> ram_addr 0x10..0x1F.
- Read q2 twice -> rd_data 0x00..0x0F from page 0, then page 1; queue_empty[2] = 1. Next write allocates page 2 (0x20); freed pages 0 and 1 follow page 15.
- Read q1 while empty -> cmd_err single pulse; no ram_re; cmd_ready stays 1.
- 16 writes to q0 -> free_empty = 1; 17th write -> cmd_err; one read of q0 -> free_empty = 0. With the macro defined, free_count tracks 16→0→1.
- Assert rst_n mid-STREAM of a write -> all outputs take their reset values immediately; INIT reruns; queue_empty = 4'b1111 afterwards.
